// File: rtl/hht_pkg.sv
// Shared definitions for the HHT column write-back buffer: default widths,
// FIFO depth and the controller state encoding.
package hht_pkg;

  localparam int HHT_DW    = 32;
  localparam int HHT_AW    = 32;
  localparam int HHT_DEPTH = 8;

  // Write-back controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hht_state_e;

endpackage

// File: rtl/hht_fifo.sv
// Synchronous FIFO with a show-ahead head word. The caller may request push
// and pop freely; a push while full and a pop while empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module hht_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage array: write the tail on an accepted push (not reset, contents
  // are only visible once counted as occupied).
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hht_wb_buffer.sv
// Column write-back buffer for the HHT datapath. Updated column elements
// are accepted into a FIFO and written to memory at consecutive addresses
// starting from the latched column base.
//
// Handshakes: an element transfers on a rising edge where in_valid and
// in_ready are both high; a memory write transfers on a rising edge where
// WR and mem_gnt are both high. While WR is high and mem_gnt is low, WR,
// addr and dataOut hold their values until the grant arrives.
module hht_wb_buffer
  import hht_pkg::*;
#(
  parameter int DW    = HHT_DW,
  parameter int AW    = HHT_AW,
  parameter int DEPTH = HHT_DEPTH
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [AW-1:0] wdata_col_base,
  input  logic [31:0]   csize,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          mem_gnt,
  output logic          WR,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dataOut,
  output logic          full,
  output logic          empty,
  output logic [31:0]   wr_count,
  output logic          done,
  output hht_state_e    o_state
);

  hht_state_e    r_state;
  hht_state_e    w_state_nxt;
  logic [AW-1:0] r_base;
  logic [31:0]   r_csize;
  logic [31:0]   r_accepted;
  logic [31:0]   r_wr_count;

  logic          w_start_ok;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_acc_inc;
  logic [31:0]   w_wr_inc;
  logic [DW-1:0] w_head;
  logic          w_full;
  logic          w_empty;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_acc_inc  = r_accepted + 32'd1;
  assign w_wr_inc   = r_wr_count + 32'd1;

  assign in_ready = (r_state == ST_RUN) && !w_full && (r_accepted < r_csize);
  assign w_push   = in_valid && in_ready;

  // Writes come only from the FIFO head, so a pushed word is visible one
  // cycle after acceptance at the earliest.
  assign WR      = !w_empty && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_pop   = WR && mem_gnt;
  assign addr    = r_base + AW'(r_wr_count);
  assign dataOut = WR ? w_head : '0;

  assign full     = w_full;
  assign empty    = w_empty;
  assign wr_count = r_wr_count;
  assign done     = (r_state == ST_DONE);
  assign o_state  = r_state;

  hht_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: RUN ends on the edge that accepts the last element, DRAIN
  // ends on the edge that writes the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (csize == 32'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_push && (w_acc_inc == r_csize)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((r_wr_count == r_csize) || (w_pop && (w_wr_inc == r_csize))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transfer parameters and progress counters; start clears both counters.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_base     <= '0;
      r_csize    <= '0;
      r_accepted <= '0;
      r_wr_count <= '0;
    end else if (w_start_ok) begin
      r_base     <= wdata_col_base;
      r_csize    <= csize;
      r_accepted <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_push) begin
        r_accepted <= w_acc_inc;
      end
      if (w_pop) begin
        r_wr_count <= w_wr_inc;
      end
    end
  end

endmodule
